por_ledger_tx: RTL and testbench
================================

# por_ledger_tx

Transmit side of the PoR ledger path. Captures each `por_valid_in` strobe and its 32-bit hash from the PL SHA-256 PoR miner, tags the hash with a sequence number and the current veto state, and buffers the record in a FIFO. It then serializes each record as an 8-byte frame on a byte-wide valid/ready stream toward the mesh egress. It runs in the 650 MHz PL domain next to the FPT core.

## Interface

Parameters:
- `DEPTH`, 16, FIFO entries; power of two, minimum 2.
- `SEQ_W`, 16, sequence counter width, 1..16; zero-extended to 16 bits in the frame.

Ports:
- `clk_650mhz`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `por_hash_in`  in  32  PoR hash; sampled when `por_valid_in`=1.
- `por_valid_in`  in  1  single-cycle capture strobe; no backpressure.
- `veto_in`  in  1  veto level; sampled with the hash.
- `tx_data`  out  8  frame byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte when `tx_valid` and `tx_ready` are both 1.
- `tx_last`  out  1  marks the final byte of the frame.
- `fifo_level`  out  $clog2(DEPTH)+1  number of stored records, excluding the frame in flight.
- `overflow_cnt`  out  16  count of dropped strobes; saturates at 0xFFFF.
- `busy`  out  1  high while a frame is in flight (state SEND).

## Operation

- Record format: {seq[SEQ_W-1:0], veto, hash[31:0]}.
- `seq` increments (mod 2^SEQ_W) on every strobe, including dropped ones. The receiver detects drops as sequence gaps.
- Write: a strobe while `fifo_level` < DEPTH writes the record.
- Drop: a strobe while `fifo_level` = DEPTH drops the record and increments `overflow_cnt`. This holds even if a pop happens in the same cycle.
- Frame byte order (index 0..7):
  - 0: 0xA5
  - 1: {7'b0, veto}
  - 2: seq16[15:8]
  - 3: seq16[7:0]
  - 4..7: hash[31:24], hash[23:16], hash[15:8], hash[7:0]
  - `tx_last` = 1 only on index 7.
- FSM has two states:
  - IDLE: if the FIFO is non-empty, pop the head into the frame register, set byte index = 0, go to SEND.
  - SEND: present byte[index]. On handshake, index increments.
  - On handshake of index 7: if the FIFO is non-empty, pop the next record in the same cycle and stay in SEND with index 0 (no bubble). Otherwise go to IDLE.
- Stream rules:
  - `tx_valid` is not withdrawn before its handshake.
  - `tx_data` and `tx_last` hold stable while `tx_valid`=1 and `tx_ready`=0.
  - `tx_valid` is not dependent combinationally on `tx_ready`.
- Simultaneous write and pop in one cycle: `fifo_level` is unchanged; both operations take effect.

## Timing

- Reset (async assert, synchronous-edge release):
  - `tx_valid`, `tx_last`, `busy` = 0; `tx_data` = 0x00.
  - `fifo_level` = 0, `overflow_cnt` = 0, `seq` = 0, state = IDLE.
- Reset asserted mid-frame: the frame is abandoned, `tx_valid` drops immediately, and FIFO contents are discarded.
- Latency, idle and empty: strobe in cycle N → written at end of N → popped at end of N+1 → `tx_valid`=1 with byte 0xA5 in cycle N+2.
- Throughput: 1 byte per cycle with `tx_ready` held at 1. Back-to-back frames are contiguous (8 cycles per record).
- `fifo_level` updates the cycle after a write or pop. `busy` rises with the first `tx_valid` of a burst and falls the cycle after the last handshake when the FIFO is empty.
- All outputs are registered.

## Test plan

1. Single frame: with DEPTH=16, SEQ_W=16, `tx_ready`=1, strobe hash 0xDEADBEEF with `veto_in`=1 at cycle N. Required: `tx_valid` first rises at N+2, bytes A5 01 00 00 DE AD BE EF in consecutive cycles, `tx_last` set only on 0xEF, `busy` high for exactly those 8 cycles.
2. Backpressure: single frame with `tx_ready` alternating 1/0. Required: each byte is held stable across stalls, the same 8 bytes are accepted in order, and `tx_valid` never drops mid-frame.
3. Back-to-back: two strobes 1 cycle apart (hash 0x11111111, then 0x22222222), `tx_ready`=1. Required: 16 contiguous valid bytes with no gap, seq 0x0000 then 0x0001, `tx_last` on bytes 8 and 16.
4. Overflow: hold `tx_ready`=0 and issue 18 strobes. Required: first record in flight, `fifo_level`=16, `overflow_cnt`=1. After `tx_ready`=1, frames with seq 0..16 are sent, and the next strobe carries seq 18.
5. Reset mid-frame: assert `rst_n`=0 after byte 3 is accepted. Required: `tx_valid`=0 and `fifo_level`=0 asynchronously. After release, a new strobe produces a frame with seq 0x0000.
6. Wrap: with SEQ_W=4, issue 17 strobes while draining. Required: seq bytes run 00 00 … 00 0F, then 00 00, with no spurious overflow.

Source files
------------

// File: rtl/por_ledger_tx.sv
// rtl/por_ledger_tx.sv - PoR hash capture FIFO and 8-byte ledger frame serializer
// Tags each PoR strobe with seq/veto, queues it, and streams it as an A5-headed frame.
module por_ledger_tx #(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic                   clk_650mhz,
    input  logic                   rst_n,
    input  logic [31:0]            por_hash_in,
    input  logic                   por_valid_in,
    input  logic                   veto_in,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            overflow_cnt,
    output logic                   busy
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int REC_W = SEQ_W + 33;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [REC_W-1:0] frame_q, frame_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_last_q, tx_last_d;
    logic [LW-1:0]    level_q, level_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [SEQ_W-1:0] seq_q;
    logic [15:0]      ovf_q;
    logic [REC_W-1:0] mem [DEPTH];

    logic full, empty, wr_en, drop, hs, last_hs, pop;

    function automatic logic [7:0] frame_byte(input logic [REC_W-1:0] rec, input logic [2:0] i);
        logic [15:0] seq16;
        logic [7:0]  b;
        seq16 = '0;
        seq16[SEQ_W-1:0] = rec[REC_W-1:33];
        case (i)
            3'd0:    b = 8'hA5;
            3'd1:    b = {7'b0, rec[32]};
            3'd2:    b = seq16[15:8];
            3'd3:    b = seq16[7:0];
            3'd4:    b = rec[31:24];
            3'd5:    b = rec[23:16];
            3'd6:    b = rec[15:8];
            default: b = rec[7:0];
        endcase
        return b;
    endfunction

    // Drop is decided on the level before any same-cycle pop.
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign wr_en   = por_valid_in && !full;
    assign drop    = por_valid_in && full;
    assign hs      = (state_q == SEND) && tx_ready;
    assign last_hs = hs && (idx_q == 3'd7);
    assign pop     = !empty && ((state_q == IDLE) || last_hs);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        tx_data_d = tx_data_q;
        tx_last_d = tx_last_q;
        if (pop) begin
            state_d   = SEND;
            idx_d     = 3'd0;
            frame_d   = mem[rd_ptr_q];
            tx_data_d = 8'hA5;
            tx_last_d = 1'b0;
        end else if (last_hs) begin
            state_d   = IDLE;
            tx_data_d = 8'h00;
            tx_last_d = 1'b0;
        end else if (hs) begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = frame_byte(frame_q, idx_q + 3'd1);
            tx_last_d = (idx_q == 3'd6);
        end
    end

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !wr_en) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_650mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            frame_q   <= '0;
            tx_data_q <= 8'h00;
            tx_last_q <= 1'b0;
            level_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            seq_q     <= '0;
            ovf_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            tx_data_q <= tx_data_d;
            tx_last_q <= tx_last_d;
            level_q   <= level_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (por_valid_in) begin
                seq_q <= seq_q + 1'b1;
            end
            if (drop && (ovf_q != 16'hFFFF)) begin
                ovf_q <= ovf_q + 16'd1;
            end
        end
    end

    // Storage needs no reset: pointers and level define which entries are live.
    always_ff @(posedge clk_650mhz) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {seq_q, veto_in, por_hash_in};
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_valid     = (state_q == SEND);
    assign tx_last      = tx_last_q;
    assign busy         = (state_q == SEND);
    assign fifo_level   = level_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_por_ledger_tx.sv
// tb/tb_por_ledger_tx.sv - randomized and directed bench for por_ledger_tx
// Two instances (16/16 and 4/4) share stimulus and are each checked against a queue model.
`timescale 1ns/1ps
module tb_por_ledger_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] por_hash_in = '0;
    logic        por_valid_in = 1'b0;
    logic        veto_in = 1'b0;
    logic        tx_ready = 1'b0;

    logic [7:0]  tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1, tx_last0, tx_last1, busy0, busy1;
    logic [4:0]  fifo_level0;
    logic [2:0]  fifo_level1;
    logic [15:0] ovf0, ovf1;

    always #5 clk = ~clk;

    por_ledger_tx #(.DEPTH(16), .SEQ_W(16)) u0 (
        .clk_650mhz(clk), .rst_n(rst_n), .por_hash_in(por_hash_in),
        .por_valid_in(por_valid_in), .veto_in(veto_in), .tx_data(tx_data0),
        .tx_valid(tx_valid0), .tx_ready(tx_ready), .tx_last(tx_last0),
        .fifo_level(fifo_level0), .overflow_cnt(ovf0), .busy(busy0)
    );

    por_ledger_tx #(.DEPTH(4), .SEQ_W(4)) u1 (
        .clk_650mhz(clk), .rst_n(rst_n), .por_hash_in(por_hash_in),
        .por_valid_in(por_valid_in), .veto_in(veto_in), .tx_data(tx_data1),
        .tx_valid(tx_valid1), .tx_ready(tx_ready), .tx_last(tx_last1),
        .fifo_level(fifo_level1), .overflow_cnt(ovf1), .busy(busy1)
    );

    typedef struct packed {
        logic [15:0] seq;
        logic        veto;
        logic [31:0] hash;
    } rec_t;

    rec_t        mq [2][$];
    int          dep [2] = '{16, 4};
    int          smod [2] = '{65536, 16};
    int          m_seq [2];
    int          m_ovf [2];
    int          m_idx [2];
    bit          m_act [2];
    logic [63:0] m_frame [2];

    logic [7:0]  acc0 [$];
    logic [7:0]  acc1 [$];
    logic        lacc0 [$];
    int          cacc0 [$];
    int          cyc = 0;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_seq[k] = 0;
            m_ovf[k] = 0;
            m_idx[k] = 0;
            m_act[k] = 1'b0;
            m_frame[k] = '0;
        end
    endtask

    // One clock of the spec rules: pop/advance from pre-edge state, then strobe write or drop.
    task automatic model_step();
        rec_t r;
        bit   hs, full, pop;
        for (int k = 0; k < 2; k++) begin
            hs   = m_act[k] && tx_ready;
            full = (mq[k].size() == dep[k]);
            pop  = (mq[k].size() > 0) && (!m_act[k] || (hs && m_idx[k] == 7));
            if (pop) begin
                r = mq[k].pop_front();
                m_frame[k] = {8'hA5, 7'b0, r.veto, r.seq, r.hash};
                m_act[k] = 1'b1;
                m_idx[k] = 0;
            end else if (hs) begin
                if (m_idx[k] == 7) m_act[k] = 1'b0;
                else m_idx[k]++;
            end
            if (por_valid_in) begin
                if (full) begin
                    if (m_ovf[k] < 65535) m_ovf[k]++;
                end else begin
                    r.seq  = 16'(m_seq[k]);
                    r.veto = veto_in;
                    r.hash = por_hash_in;
                    mq[k].push_back(r);
                end
                m_seq[k] = (m_seq[k] + 1) % smod[k];
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cyc++;
                if (tx_valid0 && tx_ready) begin
                    acc0.push_back(tx_data0);
                    lacc0.push_back(tx_last0);
                    cacc0.push_back(cyc);
                end
                if (tx_valid1 && tx_ready) acc1.push_back(tx_data1);
                model_step();
            end
        end
    end

    task automatic cmp(int k, logic v, logic [7:0] d, logic l, logic b, int lvl, int ovf);
        logic [63:0] f;
        f = m_frame[k];
        chk($sformatf("u%0d tx_valid", k), 32'(v), 32'(m_act[k]));
        chk($sformatf("u%0d busy", k), 32'(b), 32'(m_act[k]));
        chk($sformatf("u%0d tx_last", k), 32'(l), 32'(m_act[k] && m_idx[k] == 7));
        if (m_act[k]) chk($sformatf("u%0d tx_data idx%0d", k, m_idx[k]), 32'(d), 32'(f[63-8*m_idx[k] -: 8]));
        chk($sformatf("u%0d fifo_level", k), lvl, mq[k].size());
        chk($sformatf("u%0d overflow_cnt", k), ovf, m_ovf[k]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cmp(0, tx_valid0, tx_data0, tx_last0, busy0, int'(fifo_level0), int'(ovf0));
                cmp(1, tx_valid1, tx_data1, tx_last1, busy1, int'(fifo_level1), int'(ovf1));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        por_valid_in = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        acc0.delete();
        acc1.delete();
        lacc0.delete();
        cacc0.delete();
        rst_n = 1'b1;
    endtask

    task automatic strobe(logic [31:0] h, logic v);
        @(negedge clk);
        por_valid_in = 1'b1;
        por_hash_in = h;
        veto_in = v;
        @(negedge clk);
        por_valid_in = 1'b0;
    endtask

    task automatic wait_acc0(int n, int budget);
        int i;
        i = 0;
        while (acc0.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait for u0 bytes", 32'(acc0.size() >= n), 32'd1);
    endtask

    task automatic check_frame(string nm, int base, logic [63:0] exp);
        if (acc0.size() < base + 8) begin
            chk({nm, " length"}, acc0.size(), base + 8);
            return;
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s byte%0d", nm, i), 32'(acc0[base+i]), 32'(exp[63-8*i -: 8]));
            chk($sformatf("%s last%0d", nm, i), 32'(lacc0[base+i]), 32'(i == 7));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int bc, pv, pr, i;
        #1 rst_n = 1'b0;
        #10;
        chk("reset tx_valid", 32'(tx_valid0), 32'd0);
        chk("reset tx_data", 32'(tx_data0), 32'h00);
        chk("reset tx_last", 32'(tx_last0), 32'd0);
        chk("reset busy", 32'(busy0), 32'd0);
        chk("reset fifo_level", 32'(fifo_level0), 32'd0);
        chk("reset overflow_cnt", 32'(ovf0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame, latency and busy width
        do_reset();
        tx_ready = 1'b1;
        @(negedge clk);
        por_valid_in = 1'b1;
        por_hash_in = 32'hDEADBEEF;
        veto_in = 1'b1;
        @(negedge clk);
        por_valid_in = 1'b0;
        chk("t1 valid at N+1", 32'(tx_valid0), 32'd0);
        @(negedge clk);
        chk("t1 valid at N+2", 32'(tx_valid0), 32'd1);
        chk("t1 first byte", 32'(tx_data0), 32'hA5);
        bc = 0;
        repeat (12) begin
            if (busy0) bc++;
            @(negedge clk);
        end
        chk("t1 busy cycles", bc, 8);
        check_frame("t1", 0, 64'hA501_0000_DEAD_BEEF);

        // Backpressure
        do_reset();
        strobe(32'hCAFEF00D, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            tx_ready = c[0];
        end
        check_frame("t2", 0, 64'hA500_0000_CAFE_F00D);
        chk("t2 byte count", acc0.size(), 8);

        // Back-to-back
        do_reset();
        tx_ready = 1'b1;
        @(negedge clk);
        por_valid_in = 1'b1;
        por_hash_in = 32'h11111111;
        veto_in = 1'b0;
        @(negedge clk);
        por_hash_in = 32'h22222222;
        @(negedge clk);
        por_valid_in = 1'b0;
        wait_acc0(16, 40);
        check_frame("t3 first", 0, 64'hA500_0000_1111_1111);
        check_frame("t3 second", 8, 64'hA500_0001_2222_2222);
        chk("t3 contiguous span", cacc0[15] - cacc0[0], 15);

        // Overflow
        do_reset();
        for (int s = 0; s < 18; s++) begin
            @(negedge clk);
            por_valid_in = 1'b1;
            por_hash_in = $urandom;
            veto_in = s[0];
        end
        @(negedge clk);
        por_valid_in = 1'b0;
        @(negedge clk);
        chk("t4 fifo_level", 32'(fifo_level0), 32'd16);
        chk("t4 overflow_cnt", 32'(ovf0), 32'd1);
        chk("t4 in flight", 32'(tx_valid0), 32'd1);
        tx_ready = 1'b1;
        wait_acc0(136, 200);
        for (int f = 0; f < 17; f++) begin
            chk($sformatf("t4 seq hi f%0d", f), 32'(acc0[8*f+2]), 32'd0);
            chk($sformatf("t4 seq lo f%0d", f), 32'(acc0[8*f+3]), f);
        end
        repeat (4) @(negedge clk);
        chk("t4 no extra frames", acc0.size(), 136);
        strobe($urandom, 1'b0);
        wait_acc0(144, 30);
        chk("t4 next seq", 32'(acc0[139]), 32'd18);

        // Reset mid-frame
        do_reset();
        tx_ready = 1'b1;
        @(negedge clk);
        por_valid_in = 1'b1;
        por_hash_in = 32'h01234567;
        repeat (3) @(negedge clk);
        por_valid_in = 1'b0;
        wait_acc0(4, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 async tx_valid", 32'(tx_valid0), 32'd0);
        chk("t5 async fifo_level", 32'(fifo_level0), 32'd0);
        chk("t5 async busy", 32'(busy0), 32'd0);
        @(negedge clk);
        acc0.delete();
        acc1.delete();
        lacc0.delete();
        cacc0.delete();
        rst_n = 1'b1;
        strobe(32'h0BADF00D, 1'b1);
        wait_acc0(8, 20);
        repeat (4) @(negedge clk);
        check_frame("t5", 0, 64'hA501_0000_0BAD_F00D);
        chk("t5 byte count", acc0.size(), 8);

        // Sequence wrap on the 4-bit instance
        do_reset();
        tx_ready = 1'b1;
        for (int s = 0; s < 17; s++) begin
            strobe($urandom, 1'b0);
            repeat (8) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        chk("t6 u1 byte count", acc1.size(), 136);
        for (int f = 0; f < 17; f++) begin
            chk($sformatf("t6 seq hi f%0d", f), 32'(acc1[8*f+2]), 32'd0);
            chk($sformatf("t6 seq lo f%0d", f), 32'(acc1[8*f+3]), f % 16);
        end
        chk("t6 u1 overflow_cnt", 32'(ovf1), 32'd0);

        // Randomized traffic under varying load and backpressure
        do_reset();
        for (int ph = 0; ph < 9; ph++) begin
            pv = (ph % 3 == 0) ? 3 : (ph % 3 == 1) ? 30 : 95;
            pr = (ph / 3 == 0) ? 100 : (ph / 3 == 1) ? 50 : 10;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                por_valid_in = ($urandom_range(99) < pv);
                por_hash_in = $urandom;
                veto_in = 1'($urandom_range(1));
                tx_ready = ($urandom_range(99) < pr);
            end
        end
        @(negedge clk);
        por_valid_in = 1'b0;
        tx_ready = 1'b1;
        i = 0;
        while ((tx_valid0 || fifo_level0 != 0) && i < 300) begin
            @(negedge clk);
            i++;
        end
        repeat (2) @(negedge clk);
        chk("drain u0 fifo_level", 32'(fifo_level0), 32'd0);
        chk("drain u0 tx_valid", 32'(tx_valid0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
